// File: rtl/seq_det_scheduler.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : seq_det_scheduler                                             |
// | Purpose  : Round-robin sharing of one serial 8-bit pattern detector       |
// |            between N_REQ requesters; reports hit/miss and bit position.  |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module seq_det_scheduler #(
  parameter int N_REQ  = 4,
  parameter int DATA_W = 32,
  parameter int DRAIN  = 2
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [N_REQ-1:0]           req,
  input  logic [8*N_REQ-1:0]         req_pattern,
  input  logic [DATA_W*N_REQ-1:0]    req_data,
  output logic [N_REQ-1:0]           grant,
  output logic                       busy,
  output logic                       done,
  output logic [$clog2(N_REQ)-1:0]   done_id,
  output logic                       hit,
  output logic [$clog2(DATA_W)-1:0]  hit_pos,
  output logic                       det_setar,
  output logic [7:0]                 det_palavra,
  output logic                       det_start,
  output logic                       det_bit,
  input  logic                       det_found
);

  localparam int ID_W  = $clog2(N_REQ);
  localparam int HP_W  = $clog2(DATA_W);
  localparam int CNT_W = $clog2(DATA_W + DRAIN + 1);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_LOAD  = 3'd1;
  localparam logic [2:0] S_START = 3'd2;
  localparam logic [2:0] S_SHIFT = 3'd3;
  localparam logic [2:0] S_DRAIN = 3'd4;
  localparam logic [2:0] S_DONE  = 3'd5;

  logic [2:0]        r_state, w_next;
  logic [ID_W-1:0]   r_ptr, r_id;
  logic [7:0]        r_pat;
  logic [DATA_W-1:0] r_sh;
  logic [CNT_W-1:0]  r_cnt;
  logic              r_hit;
  logic [HP_W-1:0]   r_hit_pos;

  logic [7:0]        w_pat_arr  [N_REQ];
  logic [DATA_W-1:0] w_data_arr [N_REQ];
  logic              w_any;
  logic [ID_W-1:0]   w_sel, w_idx;
  logic [ID_W:0]     w_sum;
  logic              w_hit_now;

  for (genvar i = 0; i < N_REQ; i++) begin : g_unpack
    assign w_pat_arr[i]  = req_pattern[8*i +: 8];
    assign w_data_arr[i] = req_data[DATA_W*i +: DATA_W];
  end

  // First requester at or above the pointer, wrapping at N_REQ.
  always_comb begin
    w_any = 1'b0;
    w_sel = '0;
    w_sum = '0;
    w_idx = '0;
    for (int k = 0; k < N_REQ; k++) begin
      w_sum = {1'b0, r_ptr} + (ID_W+1)'(k);
      if (w_sum >= (ID_W+1)'(N_REQ)) w_sum = w_sum - (ID_W+1)'(N_REQ);
      w_idx = w_sum[ID_W-1:0];
      if (!w_any && req[w_idx]) begin
        w_any = 1'b1;
        w_sel = w_idx;
      end
    end
  end

  // Found flags seen in the first DRAIN cycles belong to no bit of this word.
  assign w_hit_now = det_found && (r_cnt >= CNT_W'(DRAIN));

  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (w_any) w_next = S_LOAD;
      S_LOAD:  w_next = S_START;
      S_START: w_next = S_SHIFT;
      S_SHIFT: begin
        if (w_hit_now)                           w_next = S_DONE;
        else if (r_cnt == CNT_W'(DATA_W - 1))    w_next = S_DRAIN;
      end
      S_DRAIN: begin
        if (w_hit_now || r_cnt == CNT_W'(DATA_W + DRAIN - 1)) w_next = S_DONE;
      end
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_ptr     <= '0;
      r_id      <= '0;
      r_pat     <= '0;
      r_sh      <= '0;
      r_cnt     <= '0;
      r_hit     <= 1'b0;
      r_hit_pos <= '0;
    end else begin
      case (r_state)
        S_IDLE: if (w_any) begin
          r_id      <= w_sel;
          r_pat     <= w_pat_arr[w_sel];
          r_sh      <= w_data_arr[w_sel];
          r_hit     <= 1'b0;
          r_hit_pos <= '0;
        end
        S_START: r_cnt <= '0;
        S_SHIFT, S_DRAIN: begin
          r_cnt <= r_cnt + 1'b1;
          if (r_state == S_SHIFT) r_sh <= r_sh << 1;
          if (w_hit_now) begin
            r_hit     <= 1'b1;
            r_hit_pos <= HP_W'(r_cnt - CNT_W'(DRAIN));
          end
        end
        S_DONE: begin
          r_ptr <= (r_id == ID_W'(N_REQ - 1)) ? '0 : r_id + 1'b1;
          r_cnt <= '0;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    grant       = '0;
    busy        = (r_state != S_IDLE);
    done        = 1'b0;
    done_id     = '0;
    hit         = 1'b0;
    hit_pos     = '0;
    det_setar   = 1'b0;
    det_palavra = (r_state != S_IDLE) ? r_pat : 8'h00;
    det_start   = 1'b0;
    det_bit     = 1'b0;
    case (r_state)
      S_LOAD: begin
        grant     = N_REQ'(1) << r_id;
        det_setar = 1'b1;
      end
      S_START: begin
        grant     = N_REQ'(1) << r_id;
        det_start = 1'b1;
      end
      S_SHIFT: begin
        grant   = N_REQ'(1) << r_id;
        det_bit = r_sh[DATA_W-1];
      end
      S_DRAIN: grant = N_REQ'(1) << r_id;
      S_DONE: begin
        done    = 1'b1;
        done_id = r_id;
        hit     = r_hit;
        hit_pos = r_hit_pos;
      end
      default: ;
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_seq_det_scheduler.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_seq_det_scheduler                                          |
// | Purpose  : Scoreboard bench for seq_det_scheduler with a detector model. |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module tb_seq_det_scheduler;

  localparam int N_REQ  = 4;
  localparam int DATA_W = 32;
  localparam int DRAIN  = 2;

  logic                      clk = 1'b0;
  logic                      rst_n = 1'b0;
  logic [N_REQ-1:0]          req;
  logic [8*N_REQ-1:0]        req_pattern;
  logic [DATA_W*N_REQ-1:0]   req_data;
  logic [N_REQ-1:0]          grant;
  logic                      busy, done, hit;
  logic [1:0]                done_id;
  logic [4:0]                hit_pos;
  logic                      det_setar, det_start, det_bit, det_found;
  logic [7:0]                det_palavra;

  always #5 clk = ~clk;

  seq_det_scheduler #(.N_REQ(N_REQ), .DATA_W(DATA_W), .DRAIN(DRAIN)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .req_pattern(req_pattern),
    .req_data(req_data), .grant(grant), .busy(busy), .done(done),
    .done_id(done_id), .hit(hit), .hit_pos(hit_pos), .det_setar(det_setar),
    .det_palavra(det_palavra), .det_start(det_start), .det_bit(det_bit),
    .det_found(det_found)
  );

  // Detector model: a bit presented in cycle t shows on det_found in t+2.
  logic [7:0] m_pat, m_sr;
  logic [3:0] m_n;
  logic       m_act, m_match;
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      m_pat <= '0; m_sr <= '0; m_n <= '0; m_act <= 1'b0;
      m_match <= 1'b0; det_found <= 1'b0;
    end else if (det_setar) begin
      m_pat <= det_palavra; m_sr <= '0; m_n <= '0; m_act <= 1'b0;
      m_match <= 1'b0; det_found <= 1'b0;
    end else if (det_start) begin
      m_sr <= '0; m_n <= '0; m_act <= 1'b1; m_match <= 1'b0;
    end else begin
      if (m_act) begin
        m_sr    <= {m_sr[6:0], det_bit};
        m_n     <= (m_n == 4'd8) ? m_n : m_n + 4'd1;
        m_match <= (m_n >= 4'd7) && ({m_sr[6:0], det_bit} == m_pat);
      end else begin
        m_match <= 1'b0;
      end
      det_found <= det_found | m_match;
    end
  end

  typedef struct {
    int id;
    bit hit;
    int pos;
    int lat;
  } exp_t;

  exp_t sb[$];
  exp_t m_e;
  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int g_cyc = 0;
  int n_done = 0;
  logic [N_REQ-1:0] prev_grant = '0;

  task automatic chk(input string name, input longint act, input longint exp_v);
    checks++;
    if (act != exp_v) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp_v);
    end
  endtask

  // Monitor: grant start recorded for latency, job results popped on done.
  always @(negedge clk) begin
    cyc++;
    if (grant != '0 && prev_grant == '0) begin
      g_cyc = cyc;
      chk("grant_onehot", longint'($onehot(grant)), 1);
      if (sb.size() > 0) chk("grant_id", grant, 1 << sb[0].id);
    end
    if (done) begin
      n_done++;
      if (sb.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_done actual_id=%0d required=no_done", done_id);
      end else begin
        m_e = sb.pop_front();
        chk("done_id", done_id, m_e.id);
        chk("hit", hit, m_e.hit);
        chk("hit_pos", hit_pos, m_e.pos);
        chk("latency", cyc - g_cyc, m_e.lat);
        chk("grant_at_done", grant, 0);
      end
    end
    prev_grant = grant;
  end

  task automatic wait_grant();
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (grant != '0) return;
    end
    checks++;
    failures++;
    $display("FAIL grant_timeout actual=none required=grant");
  endtask

  task automatic wait_done(input int target);
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (n_done >= target) return;
    end
    checks++;
    failures++;
    $display("FAIL done_timeout actual=%0d required=%0d", n_done, target);
  endtask

  task automatic run_single(input int id, input logic [7:0] pat, input logic [31:0] data,
                            input bit h, input int pos, input int lat);
    int tgt;
    req_pattern[8*id +: 8]          = pat;
    req_data[DATA_W*id +: DATA_W]   = data;
    sb.push_back('{id, h, pos, lat});
    tgt = n_done + 1;
    req = N_REQ'(1) << id;
    wait_grant();
    req = '0;
    wait_done(tgt);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1);
  end

  initial begin
    int tgt;
    req = '0;
    req_pattern = '0;
    req_data = '0;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_grant", grant, 0);
    chk("rst_done", done, 0);
    chk("rst_palavra", det_palavra, 0);
    chk("rst_setar", det_setar, 0);
    chk("rst_start", det_start, 0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("idle_no_req_busy", busy, 0);

    // Hits have latency pos+5 (LOAD, START, pos+1 bits, DRAIN); miss is 36.
    run_single(0, 8'hA5, 32'h00A5_0000, 1'b1, 15, 20);
    run_single(1, 8'hFF, 32'h0F0F_0F0F, 1'b0, 0, 36);
    run_single(2, 8'hA5, 32'h0000_00A5, 1'b1, 31, 36);
    run_single(3, 8'hA5, 32'hA500_0000, 1'b1, 7, 12);

    // Round-robin with all requesters active; pointer is back at 0.
    req_pattern = {4{8'hA5}};
    req_data    = {32'hA500_0000, 32'h00A5_0000, 32'h0000_A500, 32'h0000_00A5};
    sb.push_back('{0, 1'b1, 31, 36});
    sb.push_back('{1, 1'b1, 23, 28});
    sb.push_back('{2, 1'b1, 15, 20});
    sb.push_back('{3, 1'b1, 7, 12});
    sb.push_back('{0, 1'b1, 31, 36});
    tgt = n_done + 4;
    req = '1;
    wait_done(tgt);
    wait_grant();
    req = '0;
    wait_done(tgt + 1);

    // Mid-job changes to req and data must not affect the latched job.
    req_data[31:0] = 32'h00A5_0000;
    sb.push_back('{0, 1'b1, 15, 20});
    tgt = n_done + 1;
    req = 4'b0001;
    wait_grant();
    repeat (5) @(negedge clk);
    req = '0;
    req_data[31:0] = 32'hA500_0000;
    wait_done(tgt);

    // Reset during SHIFT at c=10 drops the job and clears the pointer.
    req = '1;
    wait_grant();
    chk("t6_grant_id1", grant, 4'b0010);
    repeat (12) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    chk("midrst_busy", busy, 0);
    chk("midrst_grant", grant, 0);
    chk("midrst_done", done, 0);
    sb.push_back('{0, 1'b1, 7, 12});
    tgt = n_done + 1;
    rst_n = 1'b1;
    wait_grant();
    req = '0;
    wait_done(tgt);

    repeat (3) @(negedge clk);
    chk("scoreboard_empty", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/seq_det_scheduler.md
Name: seq_det_scheduler

Overview:
Round-robin scheduler that shares one serial 8-bit pattern detector between N_REQ requesters. For each granted job it programs the detector with the requester's pattern, starts it, and shifts the requester's DATA_W-bit word into it MSB first. It watches the detector's sticky found flag and reports hit/miss and the bit position to the requester. It sits between the client blocks and the detector instance.

Parameters:
N_REQ, 4, number of requesters (2..8)
DATA_W, 32, bits per search word (8..64)
DRAIN, 2, cycles from presenting a bit on det_bit to the detector's found flag reflecting it

Ports:
clk  in  1  clock
rst_n  in  1  reset, synchronous, active-low
req  in  N_REQ  per-requester job request; level, sampled only in IDLE
req_pattern  in  8*N_REQ  pattern for requester i at [8i+7:8i]
req_data  in  DATA_W*N_REQ  search word for requester i at [DATA_W*i +: DATA_W]
grant  out  N_REQ  one-hot; held for the whole job
busy  out  1  high whenever state != IDLE
done  out  1  one-cycle pulse at job end
done_id  out  clog2(N_REQ)  index of the finished requester; valid with done
hit  out  1  pattern found; valid with done
hit_pos  out  clog2(DATA_W)  MSB-first index of the last bit of the match; 0 when hit=0
det_setar  out  1  detector pattern-load strobe
det_palavra  out  8  pattern to detector
det_start  out  1  detector start strobe
det_bit  out  1  serial bit to detector
det_found  in  1  detector found flag; sticky until the next det_setar

Behaviour:
- Reset (synchronous, rst_n=0 at posedge): state=IDLE, all outputs 0, RR pointer=0, counters=0. This applies at any point mid-job. The job is dropped and done is not pulsed.
- FSM: IDLE -> LOAD -> START -> SHIFT -> DRAIN -> DONE -> IDLE.
- IDLE: if any req is high, pick the first set bit searching from ptr upward with wrap. Latch its pattern, data and id. Assert grant and go to LOAD. If no req is high, stay in IDLE.
- LOAD (1 cycle): det_setar=1, det_palavra=latched pattern, det_bit=0.
- START (1 cycle): det_start=1, det_bit=0. Set counter c=0.
- SHIFT: each cycle det_bit = data[DATA_W-1-c], then c increments.
  - When c reaches DATA_W, go to DRAIN.
- DRAIN: det_bit=0. c keeps incrementing. Exit to DONE when c = DATA_W+DRAIN.
- Found check in SHIFT and DRAIN: if det_found=1 and c >= DRAIN, record hit=1 and hit_pos = c-DRAIN, then go to DONE immediately (early abort).
  - det_found seen while c < DRAIN is ignored as stale.
- DONE (1 cycle): done=1, done_id, hit, hit_pos. grant drops in the same cycle. ptr = done_id+1 mod N_REQ. Next state is IDLE.
- det_palavra holds the latched pattern throughout the job and returns to 0 in IDLE.
- Dropping req mid-job has no effect; the job completes. Changing req_pattern/req_data after grant has no effect because the values are latched.
- A requester holding req high is re-granted only after the other active requesters have had their turns.
- Job length:
  - Miss: 1+1+DATA_W+DRAIN cycles, then the DONE cycle.
  - Hit: ends DRAIN cycles after the last matching bit.
- Counter width: clog2(DATA_W+DRAIN+1). hit_pos is truncated to clog2(DATA_W) bits and is always < DATA_W.

Test Plan:
1. Single hit: req=0001, pattern0=0xA5, data0=0x00A50000 → hit=1, hit_pos=15, done_id=0. done arrives 2+16+2 cycles after grant, the early abort.
2. Miss: req=0010, pattern1=0xFF, data1=0x0F0F0F0F → hit=0, hit_pos=0, done_id=1. done arrives 2+32+2 cycles after grant.
3. Tail boundary: pattern=0xA5, data=0x000000A5 → hit=1, hit_pos=31. The found flag is caught in DRAIN.
4. Round-robin: req=1111 held across jobs → grant sequence 0,1,2,3,0. grant is always one-hot, with one job per grant.
5. Mid-job changes: drop req and change req_data during SHIFT → the job finishes using the latched data; hit/hit_pos match the original word.
6. Reset mid-SHIFT: rst_n=0 for 1 cycle at c=10 → next cycle busy=0, grant=0, no done pulse. ptr=0, so with req=1111 the next grant is requester 0.
